mem_access_unit: RTL

// - Memory-stage access engine between the multicycle main controller and a 32-bit data memory.
// - Takes one load/store command per request: memwrite/ltype/dtype encodings plus address and store data.
// - Runs 1 or 2 bus beats with a req/ack handshake, then returns aligned, extended 64-bit load data.
// - Raises done so the controller advances out of its MEM_* state; busy lets it stall.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/load_align.sv | 25 ++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared command encodings, state type and decode helpers for the
// memory-stage access engine.
package mips_pkg;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SB   = 2'b10;
  localparam logic [1:0] MW_SD   = 2'b11;

  localparam logic [1:0] LT_W    = 2'b00;
  localparam logic [1:0] LT_LBU  = 2'b01;
  localparam logic [1:0] LT_LB   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic [1:0] memwrite;
    logic [1:0] ltype;
    logic       dtype;
  } mau_cmd_t;

  function automatic logic cmd_is_load(mau_cmd_t c);
    return c.memwrite == MW_NONE;
  endfunction

  function automatic logic cmd_is_dword(mau_cmd_t c);
    return (c.memwrite == MW_SD) || (cmd_is_load(c) && c.dtype);
  endfunction

  function automatic logic cmd_is_byte(mau_cmd_t c);
    return (c.memwrite == MW_SB) ||
           (cmd_is_load(c) && !c.dtype && (c.ltype == LT_LB || c.ltype == LT_LBU));
  endfunction

  // Byte accesses never fault; doublewords need 8-byte, everything else 4-byte alignment.
  function automatic logic cmd_misaligned(mau_cmd_t c, logic [2:0] a);
    if (cmd_is_dword(c)) return a != 3'b000;
    if (!cmd_is_byte(c)) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte lane (or the whole word) out of a 32-bit bus
// word and sign/zero extends it to the datapath width.
module load_align
  import mips_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [31:0]   word,
  input  logic [1:0]    lane,
  input  logic [1:0]    ltype,
  output logic [DW-1:0] result
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = word[{lane, 3'b000} +: 8];
    case (ltype)
      LT_LB:   result = {{(DW-8){lane_byte[7]}}, lane_byte};
      LT_LBU:  result = {{(DW-8){1'b0}}, lane_byte};
      default: result = {{(DW-32){word[31]}}, word};
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: runs one or two 32-bit bus beats per load/store
// command and hands back aligned, extended load data with a done pulse.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    memwrite,
  input  logic [1:0]    ltype,
  input  logic          dtype,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  mau_state_t    state;
  mau_cmd_t      cmd;
  mau_cmd_t      new_cmd;
  logic          new_misaligned;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [31:0]   lo_word;
  logic          err_q;
  logic [DW-1:0] aligned;
  logic          is_load;
  logic          is_dword;
  logic          is_byte;
  logic [AW-1:0] base;

  assign new_cmd        = '{memwrite: memwrite, ltype: ltype, dtype: dtype};
  assign new_misaligned = cmd_misaligned(new_cmd, addr[2:0]);

  assign is_load  = cmd_is_load(cmd);
  assign is_dword = cmd_is_dword(cmd);
  assign is_byte  = cmd_is_byte(cmd);
  assign base     = {addr_q[AW-1:2], 2'b00};

  load_align #(.DW(DW)) u_load_align (
    .word   (mem_rdata),
    .lane   (addr_q[1:0]),
    .ltype  (cmd.ltype),
    .result (aligned)
  );

  // rdata only moves on the final beat of a load; stores and faults keep the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cmd     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_word <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cmd     <= new_cmd;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= new_misaligned;
            state   <= new_misaligned ? RESP : BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (is_dword) begin
              lo_word <= mem_rdata;
              state   <= BEAT1;
            end else begin
              if (is_load) rdata <= aligned;
              state <= RESP;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            if (is_load) rdata <= DW'({mem_rdata, lo_word});
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = state != IDLE;
  assign done = state == RESP;
  assign err  = done && err_q;

  // Bus signals are pure decodes of state, so an async reset drops mem_req at once.
  always_comb begin
    mem_req   = (state == BEAT0) || (state == BEAT1);
    mem_we    = mem_req && !is_load;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (mem_req) begin
      mem_addr = (state == BEAT1) ? base + AW'(4) : base;
      mem_be   = is_byte ? (4'b0001 << addr_q[1:0]) : 4'b1111;
      if (mem_we) begin
        case (cmd.memwrite)
          MW_SB:   mem_wdata = {4{wdata_q[7:0]}};
          MW_SD:   mem_wdata = (state == BEAT1) ? wdata_q[63:32] : wdata_q[31:0];
          default: mem_wdata = wdata_q[31:0];
        endcase
      end
    end
  end

endmodule
